// File: rtl/karatsuba_pkg.sv
// Shared helpers for the Karatsuba multiplier: latency and the derived half/sum/extended widths.
package karatsuba_pkg;

  // Edges from an accepted transfer to output_tvalid.
  function automatic int lat(input int mul_stages);
    return mul_stages + 3;
  endfunction

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic int sum_w(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int ext_w(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/mult_stage_pipe.sv
// Unsigned AW x BW multiplier followed by STAGES enabled registers.
module mult_stage_pipe #(
  parameter int AW     = 16,
  parameter int BW     = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [AW-1:0]      a,
  input  logic [BW-1:0]      b,
  output logic [AW+BW-1:0]   p
);

  localparam int PW = AW + BW;

  logic [PW-1:0]             prod;
  logic [STAGES:1][PW-1:0]   pipe;

  // Operands widened to the full product width so the multiply is not truncated.
  assign prod = {{BW{1'b0}}, a} * {{AW{1'b0}}, b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else if (en) begin
      pipe[1] <= prod;
      for (int i = 2; i <= STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[STAGES];

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// One-level Karatsuba WIDTH x WIDTH unsigned multiplier, fully pipelined with a single global stall enable.
module karatsuba_mult_pipe
  import karatsuba_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int USER_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     input_a_tdata,
  input  logic                 input_a_tvalid,
  output logic                 input_a_tready,
  input  logic [WIDTH-1:0]     input_b_tdata,
  input  logic                 input_b_tvalid,
  output logic                 input_b_tready,
  input  logic [USER_W-1:0]    input_tuser,
  output logic [2*WIDTH-1:0]   output_tdata,
  output logic [USER_W-1:0]    output_tuser,
  output logic                 output_tvalid,
  input  logic                 output_tready
);

  localparam int H      = half_w(WIDTH);
  localparam int SW     = sum_w(WIDTH);
  localparam int EW     = ext_w(WIDTH);
  localparam int MW     = 2*H + 1;
  localparam int PW     = 2*WIDTH;
  localparam int STAGES = lat(MUL_STAGES);

  typedef struct packed {
    logic [H-1:0]  a_h;
    logic [H-1:0]  a_l;
    logic [H-1:0]  b_h;
    logic [H-1:0]  b_l;
    logic [SW-1:0] sa;
    logic [SW-1:0] sb;
  } s0_t;

  logic                           en, xfer;
  s0_t                            s0_q;
  logic [STAGES:0]                vld_pipe;
  logic [STAGES:0][USER_W-1:0]    usr_pipe;
  logic [2*H-1:0]                 p_hi, p_lo, p_hi_m, p_lo_m, p_hi_p;
  logic [EW-1:0]                  p_e;
  logic [MW-1:0]                  mid_d, mid_m;
  logic [PW-1:0]                  lo_d, lo_p, prod_d, prod_q;

  assign en             = !output_tvalid | output_tready;
  assign input_a_tready = en & input_b_tvalid;
  assign input_b_tready = en & input_a_tvalid;
  assign xfer           = en & input_a_tvalid & input_b_tvalid;

  // S0: split halves and pre-add, keeping the carry of each half sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_q <= '0;
    end else if (xfer) begin
      s0_q.a_h <= input_a_tdata[WIDTH-1:H];
      s0_q.a_l <= input_a_tdata[H-1:0];
      s0_q.b_h <= input_b_tdata[WIDTH-1:H];
      s0_q.b_l <= input_b_tdata[H-1:0];
      s0_q.sa  <= {1'b0, input_a_tdata[WIDTH-1:H]} + {1'b0, input_a_tdata[H-1:0]};
      s0_q.sb  <= {1'b0, input_b_tdata[WIDTH-1:H]} + {1'b0, input_b_tdata[H-1:0]};
    end
  end

  mult_stage_pipe #(.AW(H), .BW(H), .STAGES(MUL_STAGES)) u_mul_hi (
    .clk(clk), .rst(rst), .en(en), .a(s0_q.a_h), .b(s0_q.b_h), .p(p_hi)
  );

  mult_stage_pipe #(.AW(H), .BW(H), .STAGES(MUL_STAGES)) u_mul_lo (
    .clk(clk), .rst(rst), .en(en), .a(s0_q.a_l), .b(s0_q.b_l), .p(p_lo)
  );

  mult_stage_pipe #(.AW(SW), .BW(SW), .STAGES(MUL_STAGES)) u_mul_e (
    .clk(clk), .rst(rst), .en(en), .a(s0_q.sa), .b(s0_q.sb), .p(p_e)
  );

  // Middle term is a_h*b_l + a_l*b_h, so it always fits in 2H+1 bits.
  assign mid_d  = MW'(p_e - {2'b00, p_hi} - {2'b00, p_lo});
  // The wide recombination is split over two stages: low part first, then the high product.
  assign lo_d   = PW'(p_lo_m) + (PW'(mid_m) << H);
  assign prod_d = (PW'(p_hi_p) << WIDTH) + lo_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_hi_m <= '0;
      p_lo_m <= '0;
      mid_m  <= '0;
      p_hi_p <= '0;
      lo_p   <= '0;
      prod_q <= '0;
    end else if (en) begin
      p_hi_m <= p_hi;
      p_lo_m <= p_lo;
      mid_m  <= mid_d;
      p_hi_p <= p_hi_m;
      lo_p   <= lo_d;
      prod_q <= prod_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      usr_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], xfer};
      usr_pipe <= {usr_pipe[STAGES-1:0], input_tuser};
    end
  end

  assign output_tdata  = prod_q;
  assign output_tuser  = usr_pipe[STAGES];
  assign output_tvalid = vld_pipe[STAGES];

endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// Directed bench for karatsuba_mult_pipe: 32-bit/2-stage and 64-bit/1-stage instances.
module tb_karatsuba_mult_pipe;
  import karatsuba_pkg::*;

  localparam int L1 = lat(2);
  localparam int L2 = lat(1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0]  a1_d, b1_d;
  logic         a1_v, b1_v, a1_r, b1_r, o1_v, o1_r;
  logic [3:0]   u1, o1_u;
  logic [63:0]  o1_d;

  logic [63:0]  a2_d, b2_d;
  logic         a2_v, b2_v, a2_r, b2_r, o2_v, o2_r;
  logic [3:0]   u2, o2_u;
  logic [127:0] o2_d;

  int total = 0;
  int bad   = 0;

  karatsuba_mult_pipe #(.WIDTH(32), .MUL_STAGES(2), .USER_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .input_a_tdata(a1_d), .input_a_tvalid(a1_v), .input_a_tready(a1_r),
    .input_b_tdata(b1_d), .input_b_tvalid(b1_v), .input_b_tready(b1_r),
    .input_tuser(u1),
    .output_tdata(o1_d), .output_tuser(o1_u), .output_tvalid(o1_v), .output_tready(o1_r)
  );

  karatsuba_mult_pipe #(.WIDTH(64), .MUL_STAGES(1), .USER_W(4)) dut2 (
    .clk(clk), .rst(rst),
    .input_a_tdata(a2_d), .input_a_tvalid(a2_v), .input_a_tready(a2_r),
    .input_b_tdata(b2_d), .input_b_tvalid(b2_v), .input_b_tready(b2_r),
    .input_tuser(u2),
    .output_tdata(o2_d), .output_tuser(o2_u), .output_tvalid(o2_v), .output_tready(o2_r)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation; checks valid stays low until exactly lat() edges after the transfer.
  task automatic send_one(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] tag, input logic [127:0] exp);
    int lt;
    lt = (sel == 1) ? L1 : L2;
    @(negedge clk);
    if (sel == 1) begin
      a1_d = a[31:0]; b1_d = b[31:0]; u1 = tag; a1_v = 1'b1; b1_v = 1'b1; o1_r = 1'b1;
    end else begin
      a2_d = a; b2_d = b; u2 = tag; a2_v = 1'b1; b2_v = 1'b1; o2_r = 1'b1;
    end
    @(posedge clk); #1;
    a1_v = 1'b0; b1_v = 1'b0; a2_v = 1'b0; b2_v = 1'b0;
    for (int k = 1; k <= lt; k++) begin
      @(posedge clk); #1;
      if (k < lt) begin
        chk("lat_early", (sel == 1) ? o1_v : o2_v, 0);
      end else begin
        chk("lat_valid", (sel == 1) ? o1_v : o2_v, 1);
        chk("data", (sel == 1) ? {64'b0, o1_d} : o2_d, exp);
        chk("tag", (sel == 1) ? o1_u : o2_u, tag);
      end
    end
  endtask

  // 20 random pairs on dut1; optionally with a randomly toggling output_tready.
  task automatic stream(input bit stall);
    logic [67:0] q[$];
    logic [67:0] e;
    logic        held;
    logic [63:0] hd;
    logic [3:0]  hu;
    int sent, got, first, last, cyc;
    sent = 0; got = 0; first = -1; last = -1; cyc = 0; held = 1'b0; hd = '0; hu = '0;
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      o1_r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < 20) begin
        a1_v = 1'b1; b1_v = 1'b1; a1_d = $urandom; b1_d = $urandom; u1 = 4'(sent);
      end else begin
        a1_v = 1'b0; b1_v = 1'b0;
      end
      #1;
      if (o1_v) begin
        if (held) begin
          chk("stall_data", o1_d, hd);
          chk("stall_tag", o1_u, hu);
        end
        if (o1_r) begin
          if (q.size() == 0) begin
            chk("stream_extra", 1, 0);
          end else begin
            e = q.pop_front();
            chk("stream_data", o1_d, e[63:0]);
            chk("stream_tag", o1_u, e[67:64]);
          end
          got++;
          held = 1'b0;
          if (first < 0) first = cyc;
          last = cyc;
        end else begin
          held = 1'b1; hd = o1_d; hu = o1_u;
          chk("stall_rdy", {a1_r, b1_r}, 0);
        end
      end
      if (a1_v && a1_r) begin
        q.push_back({u1, 64'(a1_d) * 64'(b1_d)});
        sent++;
      end
    end
    @(negedge clk);
    a1_v = 1'b0; b1_v = 1'b0; o1_r = 1'b1;
    chk("stream_count", got, 20);
    chk("stream_left", q.size(), 0);
    if (!stall) chk("stream_b2b", last - first + 1, 20);
  endtask

  initial begin
    int nv;
    a1_d = '0; b1_d = '0; a1_v = 1'b0; b1_v = 1'b1; u1 = '0; o1_r = 1'b1;
    a2_d = '0; b2_d = '0; a2_v = 1'b0; b2_v = 1'b0; u2 = '0; o2_r = 1'b1;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", o1_v, 0);
    chk("rst_data", o1_d, 0);
    chk("rst_tag", o1_u, 0);
    chk("rst_a_rdy", a1_r, 1);
    chk("rst_b_rdy", b1_r, 0);
    chk("rst2_valid", o2_v, 0);
    chk("rst2_data", o2_d, 0);
    b1_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    send_one(1, 64'h12345678, 64'h9ABCDEF0, 4'h3, 128'h0B00EA4E242D2080);
    send_one(1, 64'hFFFFFFFF, 64'hFFFFFFFF, 4'h1, 128'hFFFFFFFE00000001);
    send_one(1, 64'h00010000, 64'h00010000, 4'h2, 128'h0000000100000000);
    send_one(1, 64'h0, 64'hFFFFFFFF, 4'h4, 128'h0);

    send_one(2, 64'h12345678, 64'h9ABCDEF0, 4'h3, 128'h0B00EA4E242D2080);
    send_one(2, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'h6,
             128'hFFFFFFFFFFFFFFFE0000000000000001);
    send_one(2, 64'h0000000100000000, 64'h0000000100000000, 4'h7,
             128'h00000000000000010000000000000000);
    send_one(2, 64'h0, 64'hFFFFFFFFFFFFFFFF, 4'h8, 128'h0);

    stream(1'b0);
    stream(1'b1);
    repeat (L1 + 2) @(negedge clk);

    // A valid alone must not be consumed
    nv = 0;
    @(negedge clk);
    a1_v = 1'b1; b1_v = 1'b0; a1_d = 32'd11; b1_d = 32'd13; u1 = 4'h9; o1_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("solo_b_rdy", b1_r, 1);
      chk("solo_a_rdy", a1_r, 0);
      if (o1_v) nv++;
      @(negedge clk);
    end
    b1_v = 1'b1;
    @(posedge clk); #1;
    a1_v = 1'b0; b1_v = 1'b0;
    for (int i = 0; i < L1 + 3; i++) begin
      @(posedge clk); #1;
      if (o1_v) begin
        nv++;
        chk("solo_data", o1_d, 143);
        chk("solo_tag", o1_u, 4'h9);
      end
    end
    chk("solo_count", nv, 1);

    // Asynchronous reset with operations in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a1_v = 1'b1; b1_v = 1'b1; a1_d = 32'(i + 3); b1_d = 32'(i + 5); u1 = 4'(i + 1);
    end
    @(negedge clk);
    a1_v = 1'b0; b1_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", o1_v, 1);
    chk("pre_rst_data", o1_d, 15);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", o1_v, 0);
    chk("async_data", o1_d, 0);
    chk("async_tag", o1_u, 0);
    a1_v = 1'b1; b1_v = 1'b1;
    #1;
    chk("async_rdy", {a1_r, b1_r}, 2'b11);
    a1_v = 1'b0; b1_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    nv = 0;
    for (int i = 0; i < L1 + 4; i++) begin
      @(posedge clk); #1;
      if (o1_v) nv++;
    end
    chk("post_rst_quiet", nv, 0);
    send_one(1, 64'h7, 64'h9, 4'h5, 128'd63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
